// File: rtl/config_register_bank.sv
// config_register_bank
//   AXI4-Lite slave holding NUM_REGS configuration/status words.
//   Read-write words are byte-writable through WSTRB; words flagged in
//   RO_MASK are live views of status_in and reject writes with SLVERR.
//   AW and W are buffered independently (one of each); a write commits
//   once both are held and no B response is outstanding.
//
// Ports
//   aclk, aresetn        clock, synchronous active-low reset
//   s_axil_aw*           write address channel (awprot ignored)
//   s_axil_w*            write data channel with byte strobes
//   s_axil_b*            write response channel (OKAY / SLVERR)
//   s_axil_ar*           read address channel (arprot ignored)
//   s_axil_r*            read data channel (OKAY / SLVERR)
//   cfg_out              flat register contents, RO slots show status_in
//   cfg_wr_pulse         one-cycle pulse per register on a committed write
//   status_in            hardware status words for RO registers
module config_register_bank #(
  parameter int unsigned                      ADDR_WIDTH   = 32,
  parameter int unsigned                      DATA_WIDTH   = 32,
  parameter int unsigned                      STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned                      NUM_REGS     = 8,
  parameter logic [ADDR_WIDTH-1:0]            OFFSET       = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]   RESET_VALUES = '0,
  parameter logic [NUM_REGS-1:0]              RO_MASK      = '0
) (
  input  logic                               aclk,
  input  logic                               aresetn,

  input  logic [ADDR_WIDTH-1:0]              s_axil_awaddr,
  input  logic [2:0]                         s_axil_awprot,
  input  logic                               s_axil_awvalid,
  output logic                               s_axil_awready,

  input  logic [DATA_WIDTH-1:0]              s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]              s_axil_wstrb,
  input  logic                               s_axil_wvalid,
  output logic                               s_axil_wready,

  output logic [1:0]                         s_axil_bresp,
  output logic                               s_axil_bvalid,
  input  logic                               s_axil_bready,

  input  logic [ADDR_WIDTH-1:0]              s_axil_araddr,
  input  logic [2:0]                         s_axil_arprot,
  input  logic                               s_axil_arvalid,
  output logic                               s_axil_arready,

  output logic [DATA_WIDTH-1:0]              s_axil_rdata,
  output logic [1:0]                         s_axil_rresp,
  output logic                               s_axil_rvalid,
  input  logic                               s_axil_rready,

  output logic [NUM_REGS*DATA_WIDTH-1:0]     cfg_out,
  output logic [NUM_REGS-1:0]                cfg_wr_pulse,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]     status_in
);

  localparam int unsigned ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Protection bits carry no meaning for this block.
  logic unused_prot;
  assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

  logic [DATA_WIDTH-1:0] regs_q   [NUM_REGS];
  logic [DATA_WIDTH-1:0] cfg_word [NUM_REGS];

  logic                  aw_full;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic                  w_full;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;

  logic [ADDR_WIDTH-1:0] wr_word;
  logic                  wr_hit;
  logic [IDX_W-1:0]      wr_idx;
  logic [ADDR_WIDTH-1:0] rd_word;
  logic                  rd_hit;
  logic [IDX_W-1:0]      rd_idx;

  logic                  commit;
  logic                  ar_hs;

  // RO slots never hold state of their own; they expose status_in directly.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
    assign cfg_word[g] = RO_MASK[g] ? status_in[g*DATA_WIDTH +: DATA_WIDTH] : regs_q[g];
    assign cfg_out[g*DATA_WIDTH +: DATA_WIDTH] = cfg_word[g];
  end

  // Word index from a byte address; the addr >= OFFSET term catches the
  // wrap-around of the subtraction for addresses below the window.
  assign wr_word = (aw_addr_q - OFFSET) >> ADDR_LSB;
  assign wr_hit  = (aw_addr_q >= OFFSET) && (wr_word < ADDR_WIDTH'(NUM_REGS));
  assign wr_idx  = wr_word[IDX_W-1:0];

  assign rd_word = (s_axil_araddr - OFFSET) >> ADDR_LSB;
  assign rd_hit  = (s_axil_araddr >= OFFSET) && (rd_word < ADDR_WIDTH'(NUM_REGS));
  assign rd_idx  = rd_word[IDX_W-1:0];

  assign s_axil_awready = !aw_full;
  assign s_axil_wready  = !w_full;
  assign s_axil_arready = !s_axil_rvalid;

  // Only one B response may be outstanding, so a held AW/W pair waits
  // until the previous response has been taken.
  assign commit = aw_full && w_full && !s_axil_bvalid;
  assign ar_hs  = s_axil_arvalid && !s_axil_rvalid;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
      end
      aw_full       <= 1'b0;
      aw_addr_q     <= '0;
      w_full        <= 1'b0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= RESP_OKAY;
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
      s_axil_rresp  <= RESP_OKAY;
      cfg_wr_pulse  <= '0;
    end else begin
      cfg_wr_pulse <= '0;

      if (s_axil_awvalid && !aw_full) begin
        aw_full   <= 1'b1;
        aw_addr_q <= s_axil_awaddr;
      end

      if (s_axil_wvalid && !w_full) begin
        w_full   <= 1'b1;
        w_data_q <= s_axil_wdata;
        w_strb_q <= s_axil_wstrb;
      end

      if (s_axil_bvalid && s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end

      // commit implies both buffers are full, so no new AW/W can land on
      // this same edge and the clears below never race an accept.
      if (commit) begin
        aw_full       <= 1'b0;
        w_full        <= 1'b0;
        s_axil_bvalid <= 1'b1;
        if (wr_hit && !RO_MASK[wr_idx]) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (w_strb_q[b]) begin
              regs_q[wr_idx][b*8 +: 8] <= w_data_q[b*8 +: 8];
            end
          end
          cfg_wr_pulse[wr_idx] <= 1'b1;
          s_axil_bresp         <= RESP_OKAY;
        end else begin
          s_axil_bresp <= RESP_SLVERR;
        end
      end

      // Reads sample the pre-commit register value on a shared edge.
      if (ar_hs) begin
        s_axil_rvalid <= 1'b1;
        if (rd_hit) begin
          s_axil_rdata <= cfg_word[rd_idx];
          s_axil_rresp <= RESP_OKAY;
        end else begin
          s_axil_rdata <= '0;
          s_axil_rresp <= RESP_SLVERR;
        end
      end else if (s_axil_rvalid && s_axil_rready) begin
        s_axil_rvalid <= 1'b0;
      end
    end
  end

endmodule
